cp0_exception_unit: RTL and testbench
=====================================

// Module: cp0_exception_unit
// PURPOSE
//  Exception source for the pipeline controller. Holds CP0 Count/Compare/Status/Cause/EPC/PRId/Config.
//  Takes MEM-stage exception flags and interrupt lines; drives exception_type_o and cp0_epc_o to the controller.
//  Updates CP0 state on exception entry and on eret. Sits beside the MEM/WB boundary.
// PARAMETERS
//  PRID_VALUE    32'h00480102  read-only PRId (reg 15) contents
//  CONFIG_VALUE  32'h00008000  read-only Config (reg 16) contents
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   reset, synchronous, active-high
//  we_i            in   1   mtc0 write strobe from WB stage
//  waddr_i         in   5   CP0 register number to write
//  wdata_i         in   32  mtc0 write data
//  raddr_i         in   5   CP0 register number to read (mfc0)
//  rdata_o         out  32  read data, combinational, forwarded from WB write
//  int_i           in   6   external hardware interrupt lines
//  mem_valid_i     in   1   MEM stage holds a real instruction (not bubble)
//  mem_pc_i        in   32  PC of MEM-stage instruction
//  mem_in_ds_i     in   1   MEM instruction is in a branch delay slot
//  mem_exc_i       in   5   {eret, ov, trap, ri, syscall} flags from earlier stages
//  exception_type_o out 32  exception code to controller; 0 = none
//  cp0_epc_o       out  32  EPC for eret target, forwarded from WB write
//  timer_int_o     out  1   timer interrupt pending
//  status_o/cause_o/epc_o out 32 each  registered architectural values
// BEHAVIOUR
//  Reset: Count=0, Compare=0, Status=32'h1000_0000 (CU0=1, EXL=0, IE=0), Cause=0, EPC=0, timer_int_o=0.
//  Forwarded view: st/ca/ep = WB write value if we_i && waddr_i matches, else register. Used by detection, rdata_o, cp0_epc_o.
//  Detection (combinational, only if mem_valid_i): priority high->low:
//   int: (ca.IP[7:0] & st.IM[7:0])!=0 && st.EXL==0 && st.IE==1 -> 32'h01
//   syscall -> 32'h08; ri -> 32'h0a; trap -> 32'h0d; ov -> 32'h0c; eret -> 32'h0e; else 0.
//   mem_valid_i==0 -> exception_type_o=0 regardless of flags.
//  Count: +1 every cycle, wraps 32'hFFFF_FFFF->0; mtc0 Count loads wdata_i instead of increment.
//  Compare: mtc0 Compare loads value and clears timer_int_o same edge (clear wins over set).
//  timer_int_o: set when Count==Compare && Compare!=0; sticky until Compare written.
//  Cause.IP[7:2] <= {int_i[5]|timer_int_o, int_i[4:0]} every cycle; only IP[1:0] writable by mtc0.
//  Status: fully writable. EPC: fully writable. PRId/Config: writes ignored.
//  Order per edge: mtc0 update first, then exception/eret update overrides touched fields.
//  Exception entry (type 01/08/0a/0d/0c): if st.EXL==0: EPC<=mem_in_ds_i?pc-4:pc, Cause.BD<=mem_in_ds_i;
//   if st.EXL==1: EPC, BD unchanged. Always: Status.EXL<=1, Cause.ExcCode<= 0x00 int, else type[4:0].
//  eret (0e): Status.EXL<=0; nothing else changes.
//  Unmapped raddr_i -> rdata_o=0. Reset mid-operation discards all pending state in one cycle.
// STRUCTURE
//  Shared package: CP0 register numbers (9,11,12,13,14,15,16), exception codes (01,08,0a,0c,0d,0e),
//   Status/Cause bit-field positions. One sub-module natural: cp0_timer (Count/Compare/timer_int).
//  Detection priority encoder and CP0 register file stay in this module.
// TESTING
//  Reset: after rst, Status=32'h1000_0000, Count increments 0,1,2 on next edges, exception_type_o=0.
//  Syscall at pc=32'h0000_0100, ds=0, EXL=0 -> type 08; next cycle EPC=100, ExcCode=08, EXL=1.
//  Overflow in delay slot pc=32'h0000_0204 -> EPC=200, BD=1; repeat with EXL=1 -> EPC stays 200.
//  Interrupt: Status=32'h1000_0401, int_i=6'b000001 -> type 01, ExcCode=0; same with EXL=1 -> type 0.
//  Timer: Compare=5 at Count=0 -> timer_int_o rises when Count==5; mtc0 Compare clears it same edge.
//  mtc0 EPC=32'h0000_0800 in WB while eret in MEM -> cp0_epc_o=800, type 0e, EXL cleared next edge.

Source files
------------

// File: rtl/cp0_exception_unit_pkg.sv
// rtl/cp0_exception_unit_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_exception_unit_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_IM_HI  = 15;
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_BD     = 31;

  typedef struct packed {
    logic eret;
    logic ov;
    logic trap;
    logic ri;
    logic syscall;
  } mem_exc_t;

  // True for codes that enter the handler (eret and none excluded).
  function automatic logic is_entry(input logic [31:0] code);
    return (code == EXC_INT) || (code == EXC_SYSCALL) || (code == EXC_RI) ||
           (code == EXC_TRAP) || (code == EXC_OV);
  endfunction

endpackage

// File: rtl/cp0_exception_unit_timer.sv
// rtl/cp0_exception_unit_timer.sv - CP0 Count/Compare pair with sticky timer interrupt
module cp0_exception_unit_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 32'd0;
      compare   <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      // A Compare write acknowledges the interrupt even if a match lands on the same edge.
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 register file and MEM-stage exception detection
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [4:0]  mem_exc_i,
  output logic [31:0] exception_type_o,
  output logic [31:0] cp0_epc_o,
  output logic        timer_int_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [31:0] status, cause, epc, count, compare;
  logic [31:0] st, ca, ep;
  logic        count_we, compare_we, status_we, cause_we, epc_we;
  logic        int_pending;
  logic [31:0] exc_type;
  mem_exc_t    exc;

  assign count_we   = we_i && (waddr_i == CP0_COUNT);
  assign compare_we = we_i && (waddr_i == CP0_COMPARE);
  assign status_we  = we_i && (waddr_i == CP0_STATUS);
  assign cause_we   = we_i && (waddr_i == CP0_CAUSE);
  assign epc_we     = we_i && (waddr_i == CP0_EPC);

  // Forwarded view: what the registers hold once the WB-stage mtc0 has landed.
  assign st = status_we ? wdata_i : status;
  assign ca = cause_we ? {cause[31:10], wdata_i[9:8], cause[7:0]} : cause;
  assign ep = epc_we ? wdata_i : epc;

  assign exc = mem_exc_t'(mem_exc_i);

  assign int_pending = (|(ca[CA_IP_HI:CA_IP_LO] & st[ST_IM_HI:ST_IM_LO])) &&
                       !st[ST_EXL] && st[ST_IE];

  always_comb begin
    exc_type = EXC_NONE;
    if (mem_valid_i) begin
      if (int_pending)      exc_type = EXC_INT;
      else if (exc.syscall) exc_type = EXC_SYSCALL;
      else if (exc.ri)      exc_type = EXC_RI;
      else if (exc.trap)    exc_type = EXC_TRAP;
      else if (exc.ov)      exc_type = EXC_OV;
      else if (exc.eret)    exc_type = EXC_ERET;
    end
  end

  cp0_exception_unit_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (wdata_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int_o)
  );

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      CP0_COUNT:   rdata_o = count_we ? wdata_i : count;
      CP0_COMPARE: rdata_o = compare_we ? wdata_i : compare;
      CP0_STATUS:  rdata_o = st;
      CP0_CAUSE:   rdata_o = ca;
      CP0_EPC:     rdata_o = ep;
      CP0_PRID:    rdata_o = PRID_VALUE;
      CP0_CONFIG:  rdata_o = CONFIG_VALUE;
      default:     rdata_o = 32'd0;
    endcase
  end

  // mtc0 result is the base value; exception entry / eret then override their fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RESET;
      cause  <= 32'd0;
      epc    <= 32'd0;
    end else begin
      status <= st;
      epc    <= ep;
      cause  <= {ca[31:16], int_i[5] | timer_int_o, int_i[4:0], ca[9:0]};
      if (is_entry(exc_type)) begin
        status[ST_EXL] <= 1'b1;
        cause[CA_EXC_HI:CA_EXC_LO] <= (exc_type == EXC_INT) ? 5'd0 : exc_type[4:0];
        if (!st[ST_EXL]) begin
          epc          <= mem_in_ds_i ? mem_pc_i - 32'd4 : mem_pc_i;
          cause[CA_BD] <= mem_in_ds_i;
        end
      end else if (exc_type == EXC_ERET) begin
        status[ST_EXL] <= 1'b0;
      end
    end
  end

  assign exception_type_o = exc_type;
  assign cp0_epc_o        = ep;
  assign status_o         = status;
  assign cause_o          = cause;
  assign epc_o            = epc;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - scoreboard bench for cp0_exception_unit
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_ds_i;
  logic [4:0]  mem_exc_i;
  logic [31:0] exception_type_o;
  logic [31:0] cp0_epc_o;
  logic        timer_int_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  cp0_exception_unit dut (
    .clk              (clk),
    .rst              (rst),
    .we_i             (we_i),
    .waddr_i          (waddr_i),
    .wdata_i          (wdata_i),
    .raddr_i          (raddr_i),
    .rdata_o          (rdata_o),
    .int_i            (int_i),
    .mem_valid_i      (mem_valid_i),
    .mem_pc_i         (mem_pc_i),
    .mem_in_ds_i      (mem_in_ds_i),
    .mem_exc_i        (mem_exc_i),
    .exception_type_o (exception_type_o),
    .cp0_epc_o        (cp0_epc_o),
    .timer_int_o      (timer_int_o),
    .status_o         (status_o),
    .cause_o          (cause_o),
    .epc_o            (epc_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0;
    mem_valid_i = 1'b0; mem_pc_i = 32'd0; mem_in_ds_i = 1'b0; mem_exc_i = 5'd0;
  endtask

  task automatic test_reset;
    idle(); int_i = 6'd0; raddr_i = 5'd9; rst = 1'b1;
    tick(); tick();
    exp_q.push_back(32'h1000_0000); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if (status_o !== exp) begin fails++; $display("FAIL reset_status: got %h expected %h", status_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cause_o !== exp) begin fails++; $display("FAIL reset_cause: got %h expected %h", cause_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (epc_o !== exp) begin fails++; $display("FAIL reset_epc: got %h expected %h", epc_o, exp); end
    mem_exc_i = 5'b00001; #1;
    checks++;
    if (exception_type_o !== 32'd0) begin fails++; $display("FAIL bubble_masks_flags: got %h expected 0", exception_type_o); end
    idle(); rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(i);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      exp = exp_q.pop_front(); checks++;
      if (rdata_o !== exp) begin fails++; $display("FAIL count_after_reset[%0d]: got %h expected %h", i, rdata_o, exp); end
    end
    checks++;
    if (timer_int_o !== 1'b0) begin fails++; $display("FAIL timer_zero_compare: got %b expected 0", timer_int_o); end
  endtask

  task automatic test_syscall;
    mem_valid_i = 1'b1; mem_pc_i = 32'h0000_0100; mem_exc_i = 5'b00001; #1;
    exp_q.push_back(32'h08);
    exp = exp_q.pop_front(); checks++;
    if (exception_type_o !== exp) begin fails++; $display("FAIL syscall_type: got %h expected %h", exception_type_o, exp); end
    exp_q.push_back(32'h0000_0100); exp_q.push_back(32'h0000_0020); exp_q.push_back(32'h1000_0002);
    tick(); idle();
    exp = exp_q.pop_front(); checks++;
    if (epc_o !== exp) begin fails++; $display("FAIL syscall_epc: got %h expected %h", epc_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cause_o !== exp) begin fails++; $display("FAIL syscall_cause: got %h expected %h", cause_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (status_o !== exp) begin fails++; $display("FAIL syscall_status: got %h expected %h", status_o, exp); end
  endtask

  task automatic test_overflow_ds;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0000;
        mem_pc_i = 32'h0000_0204; mem_in_ds_i = 1'b1;
      end else begin
        mem_pc_i = 32'h0000_0304; mem_in_ds_i = 1'b0;
      end
      mem_valid_i = 1'b1; mem_exc_i = 5'b01000; #1;
      exp_q.push_back(32'h0c); exp_q.push_back(32'h0000_0200);
      exp_q.push_back(32'h8000_0030); exp_q.push_back(32'h1000_0002);
      exp = exp_q.pop_front(); checks++;
      if (exception_type_o !== exp) begin fails++; $display("FAIL ov_type[%0d]: got %h expected %h", r, exception_type_o, exp); end
      tick(); idle();
      exp = exp_q.pop_front(); checks++;
      if (epc_o !== exp) begin fails++; $display("FAIL ov_epc[%0d]: got %h expected %h", r, epc_o, exp); end
      exp = exp_q.pop_front(); checks++;
      if (cause_o !== exp) begin fails++; $display("FAIL ov_cause[%0d]: got %h expected %h", r, cause_o, exp); end
      exp = exp_q.pop_front(); checks++;
      if (status_o !== exp) begin fails++; $display("FAIL ov_status[%0d]: got %h expected %h", r, status_o, exp); end
    end
  endtask

  task automatic test_interrupt;
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0401; int_i = 6'b000001;
    tick(); idle();
    exp_q.push_back(32'h8000_0430);
    exp = exp_q.pop_front(); checks++;
    if (cause_o !== exp) begin fails++; $display("FAIL int_ip_latched: got %h expected %h", cause_o, exp); end
    mem_valid_i = 1'b1; mem_pc_i = 32'h0000_0400; mem_exc_i = 5'b00001; #1;
    exp_q.push_back(32'h01); exp_q.push_back(32'h0000_0400);
    exp_q.push_back(32'h0000_0400); exp_q.push_back(32'h1000_0403);
    exp = exp_q.pop_front(); checks++;
    if (exception_type_o !== exp) begin fails++; $display("FAIL int_type: got %h expected %h", exception_type_o, exp); end
    tick(); idle();
    exp = exp_q.pop_front(); checks++;
    if (epc_o !== exp) begin fails++; $display("FAIL int_epc: got %h expected %h", epc_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (cause_o !== exp) begin fails++; $display("FAIL int_cause: got %h expected %h", cause_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (status_o !== exp) begin fails++; $display("FAIL int_status: got %h expected %h", status_o, exp); end
    mem_valid_i = 1'b1; #1;
    checks++;
    if (exception_type_o !== 32'd0) begin fails++; $display("FAIL int_masked_exl: got %h expected 0", exception_type_o); end
    idle(); int_i = 6'd0;
    tick();
  endtask

  task automatic test_priority;
    logic [4:0]  flags [0:5];
    logic [31:0] codes [0:5];
    flags = '{5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
    codes = '{32'h08, 32'h0a, 32'h0d, 32'h0c, 32'h0e, 32'h00};
    for (int i = 0; i < 6; i++) exp_q.push_back(codes[i]);
    for (int i = 0; i < 6; i++) begin
      mem_valid_i = 1'b1; mem_exc_i = flags[i]; #1;
      exp = exp_q.pop_front(); checks++;
      if (exception_type_o !== exp) begin fails++; $display("FAIL priority[%0d]: got %h expected %h", i, exception_type_o, exp); end
    end
    idle();
  endtask

  task automatic test_timer;
    raddr_i = 5'd9;
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'd0; tick();
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd5; tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'd2 + i);
      exp_q.push_back((i >= 4) ? 32'd1 : 32'd0);
      exp_q.push_back((i >= 5) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = exp_q.pop_front(); checks++;
      if (rdata_o !== exp) begin fails++; $display("FAIL timer_count[%0d]: got %h expected %h", i, rdata_o, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'd0, timer_int_o} !== exp) begin fails++; $display("FAIL timer_int[%0d]: got %b expected %h", i, timer_int_o, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'd0, cause_o[15]} !== exp) begin fails++; $display("FAIL timer_ip7[%0d]: got %b expected %h", i, cause_o[15], exp); end
    end
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'h30; tick();
    checks++;
    if (timer_int_o !== 1'b0) begin fails++; $display("FAIL timer_clear: got %b expected 0", timer_int_o); end
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h2f; tick();
    idle(); tick();
    checks++;
    if (timer_int_o !== 1'b0) begin fails++; $display("FAIL timer_early: got %b expected 0", timer_int_o); end
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'h40; tick();
    idle(); raddr_i = 5'd11; #1;
    checks++;
    if (timer_int_o !== 1'b0) begin fails++; $display("FAIL timer_clear_wins: got %b expected 0", timer_int_o); end
    checks++;
    if (rdata_o !== 32'h40) begin fails++; $display("FAIL compare_read: got %h expected 00000040", rdata_o); end
  endtask

  task automatic test_eret_fwd;
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_0800; raddr_i = 5'd14;
    mem_valid_i = 1'b1; mem_exc_i = 5'b10000; #1;
    exp_q.push_back(32'h0000_0800); exp_q.push_back(32'h0e); exp_q.push_back(32'h0000_0800);
    exp = exp_q.pop_front(); checks++;
    if (cp0_epc_o !== exp) begin fails++; $display("FAIL eret_epc_fwd: got %h expected %h", cp0_epc_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (exception_type_o !== exp) begin fails++; $display("FAIL eret_type: got %h expected %h", exception_type_o, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rdata_o !== exp) begin fails++; $display("FAIL eret_rdata_fwd: got %h expected %h", rdata_o, exp); end
    tick(); idle();
    checks++;
    if (status_o !== 32'h1000_0401) begin fails++; $display("FAIL eret_status: got %h expected 10000401", status_o); end
    checks++;
    if (epc_o !== 32'h0000_0800) begin fails++; $display("FAIL eret_epc: got %h expected 00000800", epc_o); end
    checks++;
    if ((cause_o & 32'h8000_007c) !== 32'd0) begin fails++; $display("FAIL eret_cause: got %h expected BD/ExcCode 0", cause_o); end
  endtask

  task automatic test_regread;
    logic [4:0] addrs [0:3];
    addrs = '{5'd15, 5'd16, 5'd3, 5'd31};
    exp_q.push_back(32'h0048_0102); exp_q.push_back(32'h0000_8000);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      raddr_i = addrs[i]; #1;
      exp = exp_q.pop_front(); checks++;
      if (rdata_o !== exp) begin fails++; $display("FAIL read_reg%0d: got %h expected %h", addrs[i], rdata_o, exp); end
    end
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0000; raddr_i = 5'd12; #1;
    checks++;
    if (rdata_o !== 32'h1000_0000) begin fails++; $display("FAIL status_read_fwd: got %h expected 10000000", rdata_o); end
    tick();
    we_i = 1'b1; waddr_i = 5'd15; wdata_i = 32'hffff_ffff; tick();
    we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hffff_ffff; tick();
    idle(); raddr_i = 5'd15; #1;
    checks++;
    if (rdata_o !== 32'h0048_0102) begin fails++; $display("FAIL prid_write_ignored: got %h expected 00480102", rdata_o); end
    checks++;
    if ((cause_o & 32'h8000_037c) !== 32'h0000_0300) begin fails++; $display("FAIL cause_write_mask: got %h expected bits 00000300", cause_o); end
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0101; mem_valid_i = 1'b1; #1;
    checks++;
    if (exception_type_o !== 32'h01) begin fails++; $display("FAIL soft_int_fwd: got %h expected 00000001", exception_type_o); end
    idle();
  endtask

  task automatic test_reset_mid;
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0003;
    mem_valid_i = 1'b1; mem_pc_i = 32'h0000_0500; mem_exc_i = 5'b00001; rst = 1'b1;
    tick();
    idle(); rst = 1'b0; raddr_i = 5'd9; #1;
    checks++;
    if (status_o !== 32'h1000_0000) begin fails++; $display("FAIL midreset_status: got %h expected 10000000", status_o); end
    checks++;
    if (epc_o !== 32'd0) begin fails++; $display("FAIL midreset_epc: got %h expected 0", epc_o); end
    checks++;
    if (cause_o !== 32'd0) begin fails++; $display("FAIL midreset_cause: got %h expected 0", cause_o); end
    checks++;
    if (rdata_o !== 32'd0 || timer_int_o !== 1'b0) begin fails++; $display("FAIL midreset_timer: count %h timer %b expected 0/0", rdata_o, timer_int_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_syscall();
    test_overflow_ds();
    test_interrupt();
    test_priority();
    test_timer();
    test_eret_fwd();
    test_regread();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
